step_idle_monitor: RTL and testbench



---
 rtl/step_idle_monitor.sv | 143 ++++++++++++++
 tb/tb_step_idle_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/step_idle_monitor.sv
// Watches the synchronized step pins for inactivity and latches a shutdown request
// when a watched channel has been idle for TIMEOUT_CYCLES while the machine is armed.
module step_idle_monitor #(
    parameter int                  NSTEPDIR       = 6,
    parameter int                  TIMEOUT_CYCLES = 480000000,
    parameter int                  TBITS          = 32,
    parameter logic [NSTEPDIR-1:0] WATCH_MASK     = 6'b100000,
    parameter int                  ARM_DEBOUNCE   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NSTEPDIR-1:0] step,
    input  logic                arm_n,
    input  logic                clear,
    output logic                shutdown,
    output logic [NSTEPDIR-1:0] alert,
    output logic                armed,
    output logic [1:0]          state,
    output logic [7:0]          idle_msb
);

    localparam logic [TBITS-1:0] TMAX  = TBITS'(TIMEOUT_CYCLES);
    localparam int               DBITS = $clog2(ARM_DEBOUNCE + 1);
    localparam logic [DBITS-1:0] DMAX  = DBITS'(ARM_DEBOUNCE);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        TRIPPED = 2'b10
    } state_e;

    logic [NSTEPDIR-1:0] step_s1_q, step_s2_q, step_prev_q, step_edge_q;
    logic                arm_s1_q, arm_s2_q;
    logic [DBITS-1:0]    deb_q, deb_d;
    logic                arm_ok;
    logic [TBITS-1:0]    cnt_q [NSTEPDIR];
    logic [TBITS-1:0]    cnt_d [NSTEPDIR];
    state_e              state_q, state_d;

    // Edge detection is registered so a pin change clears its counter three edges after sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_s1_q   <= '0;
            step_s2_q   <= '0;
            step_prev_q <= '0;
            step_edge_q <= '0;
            arm_s1_q    <= 1'b0;
            arm_s2_q    <= 1'b0;
        end else begin
            step_s1_q   <= step;
            step_s2_q   <= step_s1_q;
            step_prev_q <= step_s2_q;
            step_edge_q <= step_s2_q ^ step_prev_q;
            arm_s1_q    <= arm_n;
            arm_s2_q    <= arm_s1_q;
        end
    end

    always_comb begin
        deb_d = deb_q;
        if (arm_s2_q) begin
            deb_d = '0;
        end else if (deb_q != DMAX) begin
            deb_d = deb_q + DBITS'(1);
        end
    end

    assign arm_ok = (deb_q == DMAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
        end else begin
            deb_q <= deb_d;
        end
    end

    // Clearing beats saturation so a step at the limit drops alert on the next cycle.
    always_comb begin
        for (int i = 0; i < NSTEPDIR; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear || step_edge_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != TMAX) begin
                cnt_d[i] = cnt_q[i] + TBITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NSTEPDIR; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSTEPDIR; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSTEPDIR; i++) begin
            alert[i] = (cnt_q[i] == TMAX);
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (arm_ok) state_d = ARMED;
                ARMED:   if (|(alert & WATCH_MASK)) state_d = TRIPPED;
                TRIPPED: state_d = TRIPPED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign shutdown = (state_q == TRIPPED);
    assign armed    = (state_q != IDLE);
    assign state    = state_q;

    // Debug view of the top byte of the highest channel's counter.
    generate
        if (TBITS >= 8) begin : g_msb_wide
            assign idle_msb = cnt_q[NSTEPDIR-1][TBITS-1 -: 8];
        end else begin : g_msb_narrow
            assign idle_msb = {{(8-TBITS){1'b0}}, cnt_q[NSTEPDIR-1]};
        end
    endgenerate

endmodule

// File: tb/tb_step_idle_monitor.sv
// Directed scoreboard bench for step_idle_monitor with a short timeout and an 8-bit
// counter so idle_msb shows the whole channel-5 counter.
module tb_step_idle_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] step = '0;
    logic       arm_n = 1'b1;
    logic       clear = 1'b0;
    logic       shutdown;
    logic [5:0] alert;
    logic       armed;
    logic [1:0] state;
    logic [7:0] idle_msb;

    int cyc = 0;
    int t0 = 0;
    int checks = 0;
    int passes = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [5:0] alert;
        logic [1:0] state;
        logic       shutdown;
        logic [7:0] msb;
    } exp_t;

    exp_t expQ[$];

    step_idle_monitor #(
        .NSTEPDIR(6),
        .TIMEOUT_CYCLES(100),
        .TBITS(8),
        .WATCH_MASK(6'b100000),
        .ARM_DEBOUNCE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .step(step),
        .arm_n(arm_n),
        .clear(clear),
        .shutdown(shutdown),
        .alert(alert),
        .armed(armed),
        .state(state),
        .idle_msb(idle_msb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic queueExpect(input int t, input string nm, input logic [5:0] al,
                               input logic [1:0] st, input logic sd, input logic [7:0] msb);
        exp_t e;
        e.cyc = t;
        e.name = nm;
        e.alert = al;
        e.state = st;
        e.shutdown = sd;
        e.msb = msb;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int t, input logic [5:0] s, input logic a, input logic c);
        waitCyc(t0 + t);
        step = s;
        arm_n = a;
        clear = c;
    endtask

    task automatic checkOutput(input exp_t e);
        logic expArmed;
        expArmed = (e.state != 2'b00);
        checks++;
        if (e.cyc != cyc) begin
            $display("[TB] FAIL %s: checked at cycle %0d, expected at cycle %0d", e.name, cyc, e.cyc);
        end else if (alert !== e.alert || state !== e.state || shutdown !== e.shutdown ||
                     armed !== expArmed || idle_msb !== e.msb) begin
            $display("[TB] FAIL %s @%0d: got alert=%b state=%b shutdown=%b armed=%b msb=%0d, expected alert=%b state=%b shutdown=%b armed=%b msb=%0d",
                     e.name, cyc, alert, state, shutdown, armed, idle_msb,
                     e.alert, e.state, e.shutdown, expArmed, e.msb);
        end else begin
            passes++;
        end
    endtask

    // Monitor: samples on the falling edge and retires every expectation that has come due.
    always @(negedge clk) begin
        exp_t e;
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            e = expQ.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] stepV;
        stepV = '0;
        tick();
        tick();
        queueExpect(cyc, "reset", 6'h00, 2'b00, 1'b0, 8'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        t0 = cyc;

        queueExpect(t0 + 99,  "idle_pre_limit",  6'h00, 2'b00, 1'b0, 8'd99);
        queueExpect(t0 + 100, "idle_limit",      6'h3F, 2'b00, 1'b0, 8'd100);
        queueExpect(t0 + 200, "idle_saturated",  6'h3F, 2'b00, 1'b0, 8'd100);
        queueExpect(t0 + 208, "step_lim_before", 6'h3F, 2'b00, 1'b0, 8'd100);
        queueExpect(t0 + 209, "step_lim_zero",   6'h1F, 2'b00, 1'b0, 8'd0);
        queueExpect(t0 + 210, "step_lim_count",  6'h1F, 2'b00, 1'b0, 8'd1);
        queueExpect(t0 + 230, "short_arm_pulse", 6'h1F, 2'b00, 1'b0, 8'd21);
        queueExpect(t0 + 246, "arm_not_yet",     6'h1F, 2'b00, 1'b0, 8'd37);
        queueExpect(t0 + 247, "armed",           6'h1F, 2'b01, 1'b0, 8'd38);
        queueExpect(t0 + 250, "unwatched_stall", 6'h1F, 2'b01, 1'b0, 8'd41);
        queueExpect(t0 + 253, "toggle_pending",  6'h1F, 2'b01, 1'b0, 8'd44);
        queueExpect(t0 + 254, "toggle_cleared",  6'h00, 2'b01, 1'b0, 8'd45);
        queueExpect(t0 + 308, "pre_trip",        6'h00, 2'b01, 1'b0, 8'd99);
        queueExpect(t0 + 309, "alert5_rise",     6'h20, 2'b01, 1'b0, 8'd100);
        queueExpect(t0 + 310, "tripped",         6'h20, 2'b10, 1'b1, 8'd100);
        queueExpect(t0 + 355, "trip_held_step",  6'h00, 2'b10, 1'b1, 8'd6);
        queueExpect(t0 + 360, "async_reset",     6'h00, 2'b00, 1'b0, 8'd0);
        queueExpect(t0 + 361, "post_reset",      6'h00, 2'b00, 1'b0, 8'd1);
        queueExpect(t0 + 386, "rearm_not_yet",   6'h00, 2'b00, 1'b0, 8'd26);
        queueExpect(t0 + 387, "rearmed",         6'h00, 2'b01, 1'b0, 8'd27);
        queueExpect(t0 + 459, "clr_pre_limit",   6'h00, 2'b01, 1'b0, 8'd99);
        queueExpect(t0 + 460, "clr_alert_rise",  6'h3F, 2'b01, 1'b0, 8'd100);
        queueExpect(t0 + 461, "clear_wins",      6'h00, 2'b00, 1'b0, 8'd0);
        queueExpect(t0 + 462, "clear_restart",   6'h00, 2'b00, 1'b0, 8'd1);
        queueExpect(t0 + 560, "clear_no_trip",   6'h00, 2'b00, 1'b0, 8'd99);
        queueExpect(t0 + 561, "idle_stall",      6'h3F, 2'b00, 1'b0, 8'd100);
        queueExpect(t0 + 577, "arm_on_alert",    6'h3F, 2'b01, 1'b0, 8'd100);
        queueExpect(t0 + 578, "trip_after_arm",  6'h3F, 2'b10, 1'b1, 8'd100);
        queueExpect(t0 + 591, "clear_tripped",   6'h00, 2'b00, 1'b0, 8'd0);
        queueExpect(t0 + 595, "stay_idle",       6'h00, 2'b00, 1'b0, 8'd4);

        stepV[5] = 1'b1;
        applyStimulus(205, stepV, 1'b1, 1'b0);
        applyStimulus(220, stepV, 1'b0, 1'b0);
        applyStimulus(223, stepV, 1'b1, 1'b0);
        applyStimulus(240, stepV, 1'b0, 1'b0);
        for (int t = 250; t <= 340; t += 10) begin
            stepV[4:0] = ~stepV[4:0];
            applyStimulus(t, stepV, 1'b1, 1'b0);
        end
        stepV[5] = 1'b0;
        applyStimulus(345, stepV, 1'b1, 1'b0);

        waitCyc(t0 + 360);
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;

        applyStimulus(380, stepV, 1'b0, 1'b0);
        applyStimulus(390, stepV, 1'b1, 1'b0);
        applyStimulus(460, stepV, 1'b1, 1'b1);
        applyStimulus(461, stepV, 1'b1, 1'b0);
        applyStimulus(570, stepV, 1'b0, 1'b0);
        applyStimulus(585, stepV, 1'b1, 1'b0);
        applyStimulus(590, stepV, 1'b1, 1'b1);
        applyStimulus(591, stepV, 1'b1, 1'b0);

        waitCyc(t0 + 600);
        @(negedge clk);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            $display("[TB] FAIL queue_drained: %0d expectations left, expected 0", expQ.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
